layer_compositor: RTL
=====================

// Module: layer_compositor
// PURPOSE
//  Parametrised N-layer pixel compositor: successor to the fixed two-object priority mux between sprite generators and the VGA RGB output.
//  Selects the highest-priority visible layer per pixel, falls back to background, registers the result, and blanks outside video_on.
//  Adds per-frame layer masking and sticky per-frame collision detection against a reference layer (player car).
// PARAMETERS
//  N_LAYERS  4  number of object layers; layer 0 = highest priority
//  RGB_W     3  colour bits per layer/pixel
//  COLL_REF  0  layer index used as collision reference (player car)
//  LIDX_W    3  width of hit_layer; 2**LIDX_W > N_LAYERS required
// PORTS
//  clk            in   1                 system clock
//  reset          in   1                 synchronous, active-high reset
//  pix_en         in   1                 pixel tick (p_tick); pipeline advances only when 1
//  frame_start    in   1                 1-clk pulse, first pixel of frame; qualified by pix_en
//  video_on_in    in   1                 active-video flag aligned with layer inputs
//  layer_on       in   N_LAYERS          per-layer pixel-hit flags
//  layer_rgb      in   N_LAYERS*RGB_W    layer k colour at [k*RGB_W +: RGB_W]
//  layer_mask     in   N_LAYERS          per-layer enable; shadowed at frame_start
//  bg_rgb         in   RGB_W             background colour
//  rgb_out        out  RGB_W             composited colour, 0 when blanked
//  video_on_out   out  1                 video_on_in delayed to match rgb_out
//  hit_layer      out  LIDX_W            winning layer index; N_LAYERS = background
//  collision      out  N_LAYERS          per-layer collision flags of last completed frame
//  collision_vld  out  1                 1-clk pulse when collision updates
// BEHAVIOUR
//  - Reset (sync, high): rgb_out=0, video_on_out=0, hit_layer=N_LAYERS, collision=0, collision_vld=0,
//    mask shadow=all 1s, collision accumulator=0, both pipeline stages cleared (video_on=0).
//  - All state changes only on clk edges with pix_en=1, except collision_vld which drops after one clk.
//  - Stage 1 (pix_en): s1_on <= layer_on & mask_eff; s1_rgb <= layer_rgb; s1_bg <= bg_rgb; s1_vid <= video_on_in.
//    mask_eff = layer_mask when frame_start=1 this tick, else mask shadow; shadow <= layer_mask on frame_start.
//  - Stage 2 (pix_en): lowest k with s1_on[k]=1 wins; rgb_out <= s1_vid ? winner rgb (or s1_bg if none) : 0;
//    hit_layer <= k or N_LAYERS; video_on_out <= s1_vid.
//  - Latency: exactly 2 pix_en ticks input -> rgb_out; pix_en=0 holds all registers.
//  - Collision accumulate (pix_en, s1_vid=1, s1_on[COLL_REF]=1): acc[k] |= s1_on[k] for k != COLL_REF; acc[COLL_REF] always 0.
//  - frame_start with pix_en: collision <= acc | hits_now; collision_vld <= 1; acc <= 0.
//    Hits occurring in stage 1 on the frame_start tick belong to the ending frame (already in stage 1 pipe).
//  - Masked layers never win, never collide; mask change takes effect only at frame_start (no mid-frame tearing).
//  - Reset mid-frame: accumulator lost, no collision_vld until next frame_start.
//  - Back-to-back frame_start ticks: each produces a pulse; second snapshot contains only that tick's hits.
// CONFIGURATION
//  LAYER_COLLISION_EN defined: collision accumulator, collision and collision_vld as above.
//  LAYER_COLLISION_EN undefined: no accumulator logic; collision tied 0, collision_vld tied 0; compositing unchanged.
// TESTING
//  - Reset: hold reset 3 clks, pix_en=1 -> rgb_out=0, hit_layer=4, collision=0, video_on_out=0.
//  - Priority: layer_on=4'b0110, layer1 rgb=3'b010, layer2=3'b100, vid=1, mask=4'hF -> 2 ticks later rgb_out=3'b010, hit_layer=1.
//  - Background/blank: layer_on=0, bg=3'b001, vid=1 -> rgb_out=3'b001, hit_layer=4; vid=0 -> rgb_out=0, video_on_out=0.
//  - Mask: frame_start with mask=4'b1101, layer_on=4'b0010 -> rgb_out=bg for whole frame; mask=4'hF mid-frame ignored until next frame_start.
//  - Collision (EN): layer_on=4'b0101 for one vid pixel, then frame_start -> collision=4'b0100, collision_vld high 1 clk; next frame no hits -> 0.
//  - Stall: pix_en low 5 clks between pixels -> outputs held, latency still 2 ticks; without EN collision stays 0.

Source files
------------

// File: rtl/layer_compositor.sv
// layer_compositor: N-layer priority pixel compositor for the VGA RGB path.
// Picks the highest-priority visible layer per pixel (layer 0 highest), falls
// back to the background colour, and blanks outside active video. Two
// register stages, both advancing only on pix_en.
// Layer masks are shadowed at frame_start, so a mask change never tears a frame.
// Optional feature macro: LAYER_COLLISION_EN enables sticky per-frame collision
// detection against layer COLL_REF. When it is undefined, collision and
// collision_vld are tied to 0.
module layer_compositor #(
  parameter int N_LAYERS = 4,
  parameter int RGB_W    = 3,
  parameter int COLL_REF = 0,
  parameter int LIDX_W   = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pix_en,
  input  logic                      frame_start,
  input  logic                      video_on_in,
  input  logic [N_LAYERS-1:0]       layer_on,
  input  logic [N_LAYERS*RGB_W-1:0] layer_rgb,
  input  logic [N_LAYERS-1:0]       layer_mask,
  input  logic [RGB_W-1:0]          bg_rgb,
  output logic [RGB_W-1:0]          rgb_out,
  output logic                      video_on_out,
  output logic [LIDX_W-1:0]         hit_layer,
  output logic [N_LAYERS-1:0]       collision,
  output logic                      collision_vld
);

  localparam logic [LIDX_W-1:0] BG_IDX = LIDX_W'(N_LAYERS);

  logic [N_LAYERS-1:0]       mask_shadow_reg;
  logic [N_LAYERS-1:0]       mask_eff;
  logic [N_LAYERS-1:0]       s1_on_reg;
  logic [N_LAYERS*RGB_W-1:0] s1_rgb_reg;
  logic [RGB_W-1:0]          s1_bg_reg;
  logic                      s1_vid_reg;
  logic [RGB_W-1:0]          rgb_out_reg;
  logic                      vid_out_reg;
  logic [LIDX_W-1:0]         hit_layer_reg;
  logic [RGB_W-1:0]          win_rgb;
  logic [LIDX_W-1:0]         win_idx;

  // The mask arriving with frame_start already applies to that first pixel.
  always_comb begin
    mask_eff = frame_start ? layer_mask : mask_shadow_reg;
  end

  // Stage 1: capture the masked hit flags, colours and video flag; shadow the mask at frame start.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_shadow_reg <= '1;
      s1_on_reg       <= '0;
      s1_rgb_reg      <= '0;
      s1_bg_reg       <= '0;
      s1_vid_reg      <= 1'b0;
    end else if (pix_en) begin
      if (frame_start)
        mask_shadow_reg <= layer_mask;
      s1_on_reg  <= layer_on & mask_eff;
      s1_rgb_reg <= layer_rgb;
      s1_bg_reg  <= bg_rgb;
      s1_vid_reg <= video_on_in;
    end
  end

  // Priority select: scan from the lowest priority upward so the lowest index set last wins.
  always_comb begin
    win_idx = BG_IDX;
    win_rgb = s1_bg_reg;
    for (int k = N_LAYERS - 1; k >= 0; k--) begin
      if (s1_on_reg[k]) begin
        win_idx = LIDX_W'(k);
        win_rgb = s1_rgb_reg[k*RGB_W +: RGB_W];
      end
    end
  end

  // Stage 2: register the winner and blank the colour outside active video.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_out_reg   <= '0;
      vid_out_reg   <= 1'b0;
      hit_layer_reg <= BG_IDX;
    end else if (pix_en) begin
      rgb_out_reg   <= s1_vid_reg ? win_rgb : '0;
      vid_out_reg   <= s1_vid_reg;
      hit_layer_reg <= win_idx;
    end
  end

  assign rgb_out      = rgb_out_reg;
  assign video_on_out = vid_out_reg;
  assign hit_layer    = hit_layer_reg;

`ifdef LAYER_COLLISION_EN
  logic [N_LAYERS-1:0] hits_now;
  logic [N_LAYERS-1:0] acc_reg;
  logic [N_LAYERS-1:0] collision_reg;
  logic                collision_vld_reg;

  // Layers overlapping the reference layer in the pixel now in stage 1. The reference never collides with itself.
  genvar gi;
  generate
    for (gi = 0; gi < N_LAYERS; gi++) begin : g_hit
      if (gi == COLL_REF) begin : g_ref
        assign hits_now[gi] = 1'b0;
      end else begin : g_oth
        assign hits_now[gi] = s1_vid_reg & s1_on_reg[COLL_REF] & s1_on_reg[gi];
      end
    end
  endgenerate

  // Accumulate hits over the frame.
  // At frame_start, the pixel still in stage 1 belongs to the ending frame, so it is folded into the snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg           <= '0;
      collision_reg     <= '0;
      collision_vld_reg <= 1'b0;
    end else begin
      collision_vld_reg <= pix_en & frame_start;
      if (pix_en) begin
        if (frame_start) begin
          collision_reg <= acc_reg | hits_now;
          acc_reg       <= '0;
        end else begin
          acc_reg <= acc_reg | hits_now;
        end
      end
    end
  end

  assign collision     = collision_reg;
  assign collision_vld = collision_vld_reg;
`else
  assign collision     = '0;
  assign collision_vld = 1'b0;
`endif

endmodule
